my_pc16: RTL and testbench



---
 rtl/my_pc16.sv | 122 ++++++++++++
 tb/tb_my_pc16.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/my_pc16.sv
// Fetch-stage program counter with jump load, call/return stack and halt; a new pc appears one cycle after its control input is sampled.
// The pc advances only when pc_valid & pc_ready; otherwise it is held stable unless a control input redirects it.

module my_inc16 (
  input  logic [15:0] a,
  output logic [15:0] y
);
  assign y = a + 16'd1;
endmodule

module my_pc16 #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic [15:0]                pc,
  output logic                       pc_valid,
  input  logic                       pc_ready,
  input  logic                       clr,
  input  logic                       load,
  input  logic                       call,
  input  logic                       ret,
  input  logic [15:0]                target,
  input  logic                       halt,
  output logic                       halted,
  output logic                       fault,
  output logic [$clog2(DEPTH):0]     depth
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

  state_t        state, state_n;
  logic [15:0]   pc_n;
  logic [15:0]   pc_inc;
  logic [DW-1:0] depth_n;
  logic          fault_n;
  logic          push;
  logic          accept;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic [15:0]   stack [DEPTH];

  my_inc16 u_inc (.a(pc), .y(pc_inc));

  assign pc_valid = (state == RUN);
  assign halted   = (state == HALTED);
  assign accept   = pc_valid & pc_ready;
  assign rd_idx   = AW'(depth - DW'(1));
  assign wr_idx   = depth[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      pc    <= RESET_PC;
      depth <= '0;
      fault <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      depth <= depth_n;
      fault <= fault_n;
    end
  end

  // Stack contents are unreachable once depth is zero, so they carry no reset.
  always_ff @(posedge clk) begin
    if (push) stack[wr_idx] <= pc_inc;
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    depth_n = depth;
    fault_n = fault;
    push    = 1'b0;
    if (clr) begin
      state_n = BOOT;
      pc_n    = RESET_PC;
      depth_n = '0;
      fault_n = 1'b0;
    end else begin
      case (state)
        BOOT: state_n = RUN;
        RUN: begin
          if (halt) begin
            state_n = HALTED;
          end else if (ret) begin
            // ret outranks call, so a simultaneous call is dropped here
            if (depth == '0) begin
              fault_n = 1'b1;
              state_n = HALTED;
            end else begin
              pc_n    = stack[rd_idx];
              depth_n = depth - DW'(1);
            end
          end else if (call) begin
            if (depth == FULL) begin
              fault_n = 1'b1;
              state_n = HALTED;
            end else begin
              push    = 1'b1;
              depth_n = depth + DW'(1);
              pc_n    = target;
            end
          end else if (load) begin
            pc_n = target;
          end else if (accept) begin
            pc_n = pc_inc;
          end
        end
        HALTED: state_n = HALTED;
        default: state_n = BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_my_pc16.sv
// Randomized and directed stimulus for my_pc16 against a queue-based reference model, checked by a scoreboard monitor.
module tb_my_pc16;

  localparam int          DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pc;
  logic        pc_valid;
  logic        pc_ready = 1'b0;
  logic        clr = 1'b0, load = 1'b0, call = 1'b0, ret = 1'b0, halt = 1'b0;
  logic [15:0] target = 16'h0;
  logic        halted, fault;
  logic [$clog2(DEPTH):0] depth;

  my_pc16 #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .clr(clr), .load(load), .call(call), .ret(ret), .target(target),
    .halt(halt), .halted(halted), .fault(fault), .depth(depth)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic        v;
    logic        h;
    logic        f;
    int          d;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model: mode 0 = booting, 1 = running, 2 = halted.
  int          m_mode;
  logic [15:0] m_pc;
  logic        m_fault;
  logic [15:0] m_stk[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode  = 0;
    m_pc    = RESET_PC;
    m_fault = 1'b0;
    m_stk.delete();
  endfunction

  function automatic void model_step(input logic c, h, r, k, l, rdy, input logic [15:0] t);
    if (c) begin
      model_reset();
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (h) m_mode = 2;
      else if (r) begin
        if (m_stk.size() == 0) begin m_fault = 1'b1; m_mode = 2; end
        else m_pc = m_stk.pop_back();
      end else if (k) begin
        if (m_stk.size() == DEPTH) begin m_fault = 1'b1; m_mode = 2; end
        else begin m_stk.push_back(m_pc + 16'd1); m_pc = t; end
      end else if (l) m_pc = t;
      else if (rdy) m_pc = m_pc + 16'd1;
    end
  endfunction

  task automatic drive_step(input logic c, h, r, k, l, rdy, input logic [15:0] t);
    exp_t e;
    clr = c; halt = h; ret = r; call = k; load = l; pc_ready = rdy; target = t;
    model_step(c, h, r, k, l, rdy, t);
    e.pc = m_pc;
    e.v  = (m_mode == 1);
    e.h  = (m_mode == 2);
    e.f  = m_fault;
    e.d  = m_stk.size();
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic c, h, r, k, l, rdy, input logic [15:0] t);
    @(negedge clk);
    drive_step(c, h, r, k, l, rdy, t);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, rdy, 16'h0);
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++)
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 49) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7,
            16'($urandom_range(0, 65535)));
  endtask

  task automatic reset_and_check(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    clr = 0; halt = 0; ret = 0; call = 0; load = 0; pc_ready = 0;
    #1;
    chk({tag, "_pc"}, 32'(pc), 32'(RESET_PC));
    chk({tag, "_valid"}, 32'(pc_valid), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_depth"}, 32'(depth), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive_step(0, 0, 0, 0, 0, 1, 16'h0);
  endtask

  // Monitor: one expected record per clock edge, compared just after the edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc_valid", 32'(pc_valid), 32'(e.v));
      chk("halted", 32'(halted), 32'(e.h));
      chk("fault", 32'(fault), 32'(e.f));
      chk("depth", 32'(depth), 32'(e.d));
      chk("pc", 32'(pc), 32'(e.pc));
    end
  end

  initial begin
    reset_and_check("reset");
    idle(4, 1);
    // stall pattern from 0005
    cycle(0, 0, 0, 0, 1, 1, 16'h0005);
    cycle(0, 0, 0, 0, 0, 1, 16'h0);
    cycle(0, 0, 0, 0, 0, 0, 16'h0);
    cycle(0, 0, 0, 0, 0, 0, 16'h0);
    cycle(0, 0, 0, 0, 0, 1, 16'h0);
    // call / return
    cycle(0, 0, 0, 0, 1, 0, 16'h0010);
    cycle(0, 0, 0, 1, 0, 0, 16'h0100);
    idle(2, 1);
    cycle(0, 0, 1, 0, 0, 1, 16'h0);
    // overflow after DEPTH nested calls
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 0, 1, 16'(16'h1000 * (i + 1)));
    idle(2, 1);
    cycle(1, 0, 0, 0, 0, 1, 16'h0);
    idle(3, 1);
    // underflow, then ignored controls until clr
    cycle(0, 0, 1, 0, 0, 1, 16'h0);
    cycle(0, 0, 0, 0, 1, 1, 16'h1234);
    cycle(0, 0, 0, 1, 0, 1, 16'h2345);
    cycle(1, 0, 0, 0, 0, 1, 16'h0);
    idle(1, 1);
    // wrap and simultaneous call+ret
    cycle(0, 0, 0, 0, 1, 0, 16'hFFFF);
    cycle(0, 0, 0, 0, 0, 1, 16'h0);
    cycle(0, 0, 0, 0, 1, 0, 16'hFFFF);
    cycle(0, 0, 0, 1, 0, 0, 16'h0200);
    cycle(0, 0, 1, 0, 0, 0, 16'h0);
    cycle(0, 0, 1, 1, 0, 0, 16'h0300);
    cycle(0, 0, 0, 0, 0, 1, 16'h0);
    // halt request, held controls ignored, clr in boot
    cycle(0, 1, 0, 0, 0, 1, 16'h0);
    cycle(0, 0, 0, 0, 1, 1, 16'h4444);
    cycle(1, 0, 0, 0, 0, 1, 16'h0);
    cycle(1, 0, 0, 0, 0, 1, 16'h0);
    idle(2, 1);
    rand_cycles(3000);
    @(posedge clk); #2;
    reset_and_check("midreset");
    rand_cycles(3000);
    @(posedge clk); #2;
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
